// File: rtl/regfile_dump_if.sv
// ----------------------------------------------------------------------------
// regfile_dump_if
// Purpose : valid/ready beat stream carrying one (register index, register
//           value) pair per beat from the register-file dump engine to its
//           consumer (debug UART / trace FIFO).
// Signals : out_valid  beat valid (driven by master)
//           out_ready  consumer accepts beat (driven by slave)
//           out_idx    register index of the current beat
//           out_data   register value of the current beat
// Modports: master = dump engine, slave = consumer.
// ----------------------------------------------------------------------------
interface regfile_dump_if #(
    parameter int XLEN = 32,
    parameter int IDXW = 5
) ();
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_idx;
    logic [XLEN-1:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// ----------------------------------------------------------------------------
// regfile_dump
// Purpose : debug/trace reader for the RV32I integer register file. On a start
//           pulse it walks every register through a spare combinational read
//           port and streams (index, value) beats out on a valid/ready stream.
//           It never writes the register file.
// Ports   : clk      clock, all state on posedge
//           reset    synchronous, active-high
//           start    request a dump (only honoured while idle)
//           busy     high from the cycle after an accepted start through the
//                    done pulse
//           done     one-cycle pulse after the last beat handshakes
//           ra       registered read address to the register-file read port
//           rd       combinational read data for ra (x0 already zero)
//           out_if   beat stream (master side)
// Config  : DUMP_SKIP_X0_EN - when defined the sweep starts at x1 (31 beats);
//           otherwise x0..x31 are reported (32 beats).
// ----------------------------------------------------------------------------
module regfile_dump #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IDXW  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IDXW-1:0]     ra,
    input  logic [XLEN-1:0]     rd,
    regfile_dump_if.master      out_if
);

`ifdef DUMP_SKIP_X0_EN
    // x0 is hardwired to zero, so it is not worth a beat.
    localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(1);
`else
    localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(0);
`endif
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_busy;
    logic            r_done;
    logic [IDXW-1:0] r_ra;
    logic            r_out_valid;
    logic [IDXW-1:0] r_out_idx;
    logic [XLEN-1:0] r_out_data;

    logic            w_handshake;
    logic            w_last;

    assign w_handshake = r_out_valid && out_if.out_ready;
    // ra is only advanced after a beat is sent, so it always names the
    // register of the beat in flight; the sweep stops on it, never wraps.
    assign w_last      = (r_ra == LAST_IDX);

    // Next-state logic of the dump sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (w_handshake) begin
                    if (w_last) begin
                        w_next_state = ST_FIN;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            ST_FIN: begin
                // start in the done cycle is deliberately dropped.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register of the dump sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered status, read address and beat payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ra        <= {IDXW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_idx   <= {IDXW{1'b0}};
            r_out_data  <= {XLEN{1'b0}};
        end else begin
            // Status follows the state being entered so it is glitch-free
            // and lines up exactly with READ/SEND/FIN.
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (w_next_state == ST_FIN);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ra <= FIRST_IDX;
                    end
                end
                ST_READ: begin
                    // rd reflects the file contents before this edge, so a
                    // write landing on this same edge is not captured.
                    r_out_data  <= rd;
                    r_out_idx   <= r_ra;
                    r_out_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (!w_last) begin
                            r_ra <= r_ra + IDXW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign ra              = r_ra;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_idx   = r_out_idx;
    assign out_if.out_data  = r_out_data;

endmodule

// File: tb/tb_regfile_dump.sv
// ----------------------------------------------------------------------------
// tb_regfile_dump
// Purpose : self-checking bench for regfile_dump. A behavioural register file
//           feeds the read port; expected beats are the list of register
//           indices to be reported, checked one by one against the stream,
//           with cycle-level expectations on READ bubbles, stalls, done and
//           busy. Honours DUMP_SKIP_X0_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_regfile_dump;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int IDXW  = 5;
`ifdef DUMP_SKIP_X0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    localparam int P_READ = 0;
    localparam int P_BEAT = 1;
    localparam int P_FIN  = 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [IDXW-1:0] ra;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] rf [NREGS];

    int n_checks;
    int n_pass;
    int cyc;

    regfile_dump_if #(.XLEN(XLEN), .IDXW(IDXW)) u_if ();

    regfile_dump #(.XLEN(XLEN), .NREGS(NREGS), .IDXW(IDXW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .ra     (ra),
        .rd     (rd),
        .out_if (u_if)
    );

    // Behavioural register file: combinational read, x0 reads as zero.
    assign rd = (ra == 5'd0) ? 32'd0 : rf[ra];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_valid"}, {31'd0, u_if.out_valid}, 32'd0);
    endtask

    task automatic load_pattern();
        for (int i = 0; i < NREGS; i++) rf[i] = 32'hA5A5_0000 + i;
        rf[0] = 32'd0;
    endtask

    task automatic load_random();
        for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
        rf[0] = 32'd0;
    endtask

    // One dump: start now, then walk the expected beat list cycle by cycle.
    // stall_idx: beat index to hold ready low for 5 cycles (-1 none).
    // abort_idx: beat index at which reset is pulsed during SEND (-1 none).
    // stray:     pulse start during beats 3 and 20 and on the done cycle.
    task automatic do_dump(input string name, input int ready_pct, input int stall_idx,
                           input int abort_idx, input bit stray);
        int  q[$];
        int  pos;
        int  phase;
        int  stall_left;
        int  t0;
        int  idx;
        bit  finished;
        bit  rdy;
        logic [31:0] exp_data;

        q = {};
        for (int i = FIRST; i < NREGS; i++) q.push_back(i);
        pos        = 0;
        stall_left = 5;
        finished   = 1'b0;

        t0    = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_first_read"}, {31'd0, busy}, 32'd1);
        chk({name, "_valid_first_read"}, {31'd0, u_if.out_valid}, 32'd0);
        phase = P_BEAT;

        for (int c = 0; c < 2000 && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            case (phase)
                P_READ: begin
                    chk({name, "_read_valid"}, {31'd0, u_if.out_valid}, 32'd0);
                    chk({name, "_read_busy"},  {31'd0, busy}, 32'd1);
                    chk({name, "_read_done"},  {31'd0, done}, 32'd0);
                    // ready while no beat is offered must be harmless
                    u_if.out_ready = ($urandom_range(1) == 1);
                    phase = P_BEAT;
                end
                P_BEAT: begin
                    idx      = q[pos];
                    exp_data = (idx == 0) ? 32'd0 : rf[idx];
                    chk({name, "_beat_valid"}, {31'd0, u_if.out_valid}, 32'd1);
                    chk({name, "_beat_idx"},   32'(u_if.out_idx), 32'(idx));
                    chk({name, "_beat_data"},  u_if.out_data, exp_data);
                    chk({name, "_beat_ra"},    32'(ra), 32'(idx));
                    chk({name, "_beat_busy"},  {31'd0, busy}, 32'd1);
                    chk({name, "_beat_done"},  {31'd0, done}, 32'd0);
                    if (idx == abort_idx) begin
                        u_if.out_ready = 1'b0;
                        reset = 1'b1;
                        @(negedge clk);
                        reset = 1'b0;
                        chk_idle({name, "_abort"});
                        chk({name, "_abort_ra"},   32'(ra), 32'd0);
                        chk({name, "_abort_idx"},  32'(u_if.out_idx), 32'd0);
                        chk({name, "_abort_data"}, u_if.out_data, 32'd0);
                        for (int k = 0; k < 3; k++) begin
                            @(negedge clk);
                            chk_idle({name, "_post_abort"});
                        end
                        finished = 1'b1;
                    end else begin
                        if (idx == stall_idx && stall_left > 0) begin
                            rdy = 1'b0;
                            stall_left--;
                        end else begin
                            rdy = ($urandom_range(99) < ready_pct);
                        end
                        u_if.out_ready = rdy;
                        if (stray && (idx == 3 || idx == 20)) start = 1'b1;
                        if (rdy) begin
                            pos++;
                            phase = (pos == q.size()) ? P_FIN : P_READ;
                        end
                    end
                end
                default: begin
                    chk({name, "_fin_done"},  {31'd0, done}, 32'd1);
                    chk({name, "_fin_busy"},  {31'd0, busy}, 32'd1);
                    chk({name, "_fin_valid"}, {31'd0, u_if.out_valid}, 32'd0);
                    if (ready_pct == 100 && stall_idx < 0) begin
                        chk({name, "_done_latency"}, 32'(cyc - t0), 32'(2 * q.size() + 1));
                    end
                    if (stray) start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    chk_idle({name, "_after_done"});
                    finished = 1'b1;
                end
            endcase
        end
        if (!finished) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        cyc            = 0;
        reset          = 1'b1;
        start          = 1'b0;
        u_if.out_ready = 1'b0;
        load_pattern();

        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_ra",   32'(ra), 32'd0);
        chk("reset_idx",  32'(u_if.out_idx), 32'd0);
        chk("reset_data", u_if.out_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        do_dump("full", 100, -1, -1, 1'b0);
        do_dump("stall", 100, 7, -1, 1'b0);
        do_dump("stray", 100, -1, -1, 1'b1);
        // starts one cycle after the previous done pulse
        do_dump("restart", 100, -1, -1, 1'b0);

        load_random();
        do_dump("abort", 100, -1, 12, 1'b0);
        do_dump("after_abort", 100, -1, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            load_random();
            do_dump("rand", 50, -1, -1, 1'b0);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
